// File: rtl/mdu_iter.sv
// mdu_iter: iterative RV32M multiply/divide unit.
// One radix-2 step per cycle on a shared hi/lo register pair: shift-add for
// multiplies (LSB first), restoring division for divides (MSB first).
// Divide-by-zero and signed overflow complete at accept without iterating.
module mdu_iter #(
   parameter int XLEN = 32
) (
   input  logic            i_clk,
   input  logic            i_reset,
   input  logic            i_flush,
   input  logic            i_valid,
   output logic            o_ready,
   input  logic [2:0]      i_md_op,
   input  logic [XLEN-1:0] i_operand_a,
   input  logic [XLEN-1:0] i_operand_b,
   output logic            o_valid,
   output logic [XLEN-1:0] o_md_data,
   output logic            o_busy
);

   localparam int CW = $clog2(XLEN);
   localparam logic [CW-1:0]   LAST = CW'(XLEN - 1);
   localparam logic [XLEN-1:0] SMIN = {1'b1, {(XLEN-1){1'b0}}};

   typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

   state_t          state, state_d;
   logic [CW-1:0]   cnt;
   logic [2:0]      op_q;
   logic            neg_a_q, neg_b_q;
   // hi: product high half / partial remainder; lo: multiplier / dividend->quotient
   logic [XLEN-1:0] hi, lo, opd;

   logic            is_div, a_sgn, b_sgn, neg_a_in, neg_b_in;
   logic [XLEN-1:0] mag_a, mag_b, fast_res;
   logic            div_zero, div_ovf, fast, accept;

   logic [XLEN:0]   mul_sum;
   logic [XLEN-1:0] div_low, div_diff;
   logic            div_borrow, qbit;
   logic [XLEN-1:0] hi_n, lo_n;
   logic [2*XLEN-1:0] prod_s;
   logic [XLEN-1:0] quo, rem, result;

   function automatic logic [XLEN-1:0] neg_x(input logic [XLEN-1:0] v, input logic n);
      return n ? (~v + XLEN'(1)) : v;
   endfunction

   function automatic logic [2*XLEN-1:0] neg_2x(input logic [2*XLEN-1:0] v, input logic n);
      return n ? (~v + (2*XLEN)'(1)) : v;
   endfunction

   // Operand decode: which operands are signed, their magnitudes, early-exit cases
   assign is_div   = i_md_op[2];
   assign a_sgn    = is_div ? ~i_md_op[0] : (i_md_op[1:0] != 2'b11);
   assign b_sgn    = is_div ? ~i_md_op[0] : ~i_md_op[1];
   assign neg_a_in = a_sgn & i_operand_a[XLEN-1];
   assign neg_b_in = b_sgn & i_operand_b[XLEN-1];
   assign mag_a    = neg_x(i_operand_a, neg_a_in);
   assign mag_b    = neg_x(i_operand_b, neg_b_in);
   assign div_zero = is_div & (i_operand_b == '0);
   assign div_ovf  = is_div & ~i_md_op[0] & (i_operand_a == SMIN) & (i_operand_b == '1);
   assign fast     = div_zero | div_ovf;
   assign fast_res = div_zero ? (i_md_op[1] ? i_operand_a : '1)
                              : (i_md_op[1] ? '0 : i_operand_a);
   assign accept   = (state == IDLE) & i_valid & ~i_flush;

   // One radix-2 step of the shared datapath
   always_comb begin
      hi_n    = hi;
      lo_n    = lo;
      mul_sum = {1'b0, hi} + (lo[0] ? {1'b0, opd} : '0);
      div_low = {hi[XLEN-2:0], lo[XLEN-1]};
      {div_borrow, div_diff} = {1'b0, div_low} - {1'b0, opd};
      // a set top bit of the old remainder means the shifted value exceeds any divisor
      qbit    = hi[XLEN-1] | ~div_borrow;
      if (op_q[2]) begin
         hi_n = qbit ? div_diff : div_low;
         lo_n = {lo[XLEN-2:0], qbit};
      end else begin
         hi_n = mul_sum[XLEN:1];
         lo_n = {mul_sum[0], lo[XLEN-1:1]};
      end
   end

   // Final sign correction and result selection from the last step's values
   always_comb begin
      prod_s = neg_2x({hi_n, lo_n}, neg_a_q ^ neg_b_q);
      quo    = neg_x(lo_n, neg_a_q ^ neg_b_q);
      rem    = neg_x(hi_n, neg_a_q);
      if (op_q[2])
         result = op_q[1] ? rem : quo;
      else
         result = (op_q[1:0] == 2'b00) ? prod_s[XLEN-1:0] : prod_s[2*XLEN-1:XLEN];
   end

   // Next-state and handshake outputs
   always_comb begin
      state_d = state;
      o_ready = 1'b0;
      o_busy  = 1'b0;
      o_valid = 1'b0;
      case (state)
         IDLE: begin
            o_ready = ~i_reset;
            if (accept) state_d = fast ? DONE : CALC;
         end
         CALC: begin
            o_busy = 1'b1;
            if (i_flush)          state_d = IDLE;
            else if (cnt == LAST) state_d = DONE;
         end
         DONE: begin
            o_busy  = 1'b1;
            o_valid = ~i_flush;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Control state, iteration counter and registered result
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         state     <= IDLE;
         cnt       <= '0;
         o_md_data <= '0;
      end else begin
         state <= state_d;
         if (state == CALC && !i_flush && cnt != LAST) cnt <= cnt + CW'(1);
         else                                          cnt <= '0;
         if (accept && fast)
            o_md_data <= fast_res;
         else if (state == CALC && !i_flush && cnt == LAST)
            o_md_data <= result;
      end
   end

   // Datapath registers: load magnitudes at accept, step during CALC
   always_ff @(posedge i_clk) begin
      if (accept) begin
         op_q    <= i_md_op;
         neg_a_q <= neg_a_in;
         neg_b_q <= neg_b_in;
         hi      <= '0;
         lo      <= is_div ? mag_a : mag_b;
         opd     <= is_div ? mag_b : mag_a;
      end else if (state == CALC) begin
         hi <= hi_n;
         lo <= lo_n;
      end
   end

endmodule

// File: tb/tb_mdu_iter.sv
// tb_mdu_iter: directed vectors, flush/reset sequences and random back-to-back
// traffic for mdu_iter at XLEN=32, plus a few XLEN=16 vectors.
module tb_mdu_iter;

   logic clk = 1'b0;
   logic rst, flush;
   logic v32, r32, ov32, busy32;
   logic [2:0] op32;
   logic [31:0] a32, b32, d32;
   logic v16, r16, ov16, busy16;
   logic [2:0] op16;
   logic [15:0] a16, b16, d16;
   bit sel16 = 1'b0;
   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   mdu_iter #(.XLEN(32)) u32 (
      .i_clk(clk), .i_reset(rst), .i_flush(flush), .i_valid(v32), .o_ready(r32),
      .i_md_op(op32), .i_operand_a(a32), .i_operand_b(b32),
      .o_valid(ov32), .o_md_data(d32), .o_busy(busy32));

   mdu_iter #(.XLEN(16)) u16 (
      .i_clk(clk), .i_reset(rst), .i_flush(flush), .i_valid(v16), .o_ready(r16),
      .i_md_op(op16), .i_operand_a(a16), .i_operand_b(b16),
      .o_valid(ov16), .o_md_data(d16), .o_busy(busy16));

   wire        mv = sel16 ? ov16 : ov32;
   wire        mr = sel16 ? r16 : r32;
   wire [31:0] md = sel16 ? {16'd0, d16} : d32;

   typedef struct {
      bit          w16;
      logic [2:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] exp;
      int          lat;
   } vec_t;

   vec_t vt[$];
   logic [31:0] exp_q[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic drive(input bit w16, input logic v, input logic [2:0] op,
                        input logic [31:0] a, input logic [31:0] b);
      if (w16) begin
         v16 = v; op16 = op; a16 = a[15:0]; b16 = b[15:0];
      end else begin
         v32 = v; op32 = op; a32 = a; b32 = b;
      end
   endtask

   // Issue one op from idle; returns result, cycle of o_valid, and whether the
   // following cycle has o_valid low and o_ready high.
   task automatic run_op(input bit w16, input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] b, output logic [31:0] res,
                         output int lat, output logic after_ok);
      sel16 = w16;
      res = '0;
      lat = -1;
      drive(w16, 1'b1, op, a, b);
      for (int c = 1; c <= 80; c++) begin
         @(posedge clk); #1;
         drive(w16, 1'b0, 3'($urandom_range(0, 7)), $urandom, $urandom);
         if (mv) begin
            lat = c;
            res = md;
            break;
         end
      end
      @(posedge clk); #1;
      after_ok = !mv && mr;
   endtask

   // Reference: RV32M semantics from plain 64-bit arithmetic
   function automatic logic [31:0] ref_md(input logic [2:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
      longint sa, sb, ua, ub;
      logic [63:0] p;
      logic [31:0] r;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      ua = longint'({32'd0, a});
      ub = longint'({32'd0, b});
      p  = '0;
      case (op)
         3'd0: begin p = sa * sb; r = p[31:0]; end
         3'd1: begin p = sa * sb; r = p[63:32]; end
         3'd2: begin p = sa * ub; r = p[63:32]; end
         3'd3: begin p = ua * ub; r = p[63:32]; end
         3'd4: begin
            if (b == 0) r = 32'hFFFF_FFFF;
            else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = a;
            else r = 32'(sa / sb);
         end
         3'd5: r = (b == 0) ? 32'hFFFF_FFFF : a / b;
         3'd6: begin
            if (b == 0) r = a;
            else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = 32'd0;
            else r = 32'(sa % sb);
         end
         default: r = (b == 0) ? a : a % b;
      endcase
      return r;
   endfunction

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] res;
      int lat;
      logic ok;
      int seen;

      vt.push_back('{1'b0, 3'd0, 32'd7,         32'hFFFF_FFFD, 32'hFFFF_FFEB, 33});
      vt.push_back('{1'b0, 3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33});
      vt.push_back('{1'b0, 3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 33});
      vt.push_back('{1'b0, 3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 33});
      vt.push_back('{1'b0, 3'd4, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 33});
      vt.push_back('{1'b0, 3'd6, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 33});
      vt.push_back('{1'b0, 3'd5, 32'hFFFF_FFFE, 32'd2,         32'h7FFF_FFFF, 33});
      vt.push_back('{1'b0, 3'd7, 32'd100,       32'd7,         32'd2,         33});
      vt.push_back('{1'b0, 3'd4, 32'h1234,      32'd0,         32'hFFFF_FFFF, 1});
      vt.push_back('{1'b0, 3'd5, 32'h1234,      32'd0,         32'hFFFF_FFFF, 1});
      vt.push_back('{1'b0, 3'd6, 32'h1234,      32'd0,         32'h1234,      1});
      vt.push_back('{1'b0, 3'd7, 32'h1234,      32'd0,         32'h1234,      1});
      vt.push_back('{1'b0, 3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1});
      vt.push_back('{1'b0, 3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         1});
      vt.push_back('{1'b1, 3'd1, 32'h8000,      32'h7FFF,      32'hC000,      17});
      vt.push_back('{1'b1, 3'd0, 32'h8000,      32'h7FFF,      32'h8000,      17});
      vt.push_back('{1'b1, 3'd4, 32'h8000,      32'hFFFF,      32'h8000,      1});
      vt.push_back('{1'b1, 3'd5, 32'd1000,      32'd7,         32'd142,       17});

      rst = 1'b1;
      flush = 1'b0;
      drive(1'b0, 1'b0, 3'd0, 32'd0, 32'd0);
      drive(1'b1, 1'b0, 3'd0, 32'd0, 32'd0);
      repeat (3) @(posedge clk);
      #1;
      check("reset data", d32, 32'd0);
      check("reset valid", {31'd0, ov32}, 32'd0);
      check("reset busy", {31'd0, busy32}, 32'd0);
      check("ready in reset", {31'd0, r32}, 32'd0);
      rst = 1'b0;
      @(posedge clk); #1;
      check("ready after reset", {31'd0, r32}, 32'd1);

      // Directed vectors
      foreach (vt[i]) begin
         run_op(vt[i].w16, vt[i].op, vt[i].a, vt[i].b, res, lat, ok);
         check($sformatf("vec%0d data", i), res, vt[i].exp);
         check($sformatf("vec%0d cycle", i), 32'(lat), 32'(vt[i].lat));
         check($sformatf("vec%0d pulse/ready", i), {31'd0, ok}, 32'd1);
      end
      sel16 = 1'b0;

      // Flush during CALC
      run_op(1'b0, 3'd7, 32'd100, 32'd7, res, lat, ok);
      check("pre-flush remu", res, 32'd2);
      drive(1'b0, 1'b1, 3'd4, 32'd1000, 32'd3);
      for (int c = 1; c <= 10; c++) begin
         @(posedge clk); #1;
         drive(1'b0, 1'b0, 3'($urandom_range(0, 7)), $urandom, $urandom);
      end
      flush = 1'b1;
      #1;
      check("flush calc valid", {31'd0, ov32}, 32'd0);
      @(posedge clk); #1;
      flush = 1'b0;
      check("flush ready", {31'd0, r32}, 32'd1);
      check("flush busy", {31'd0, busy32}, 32'd0);
      check("flush data kept", d32, 32'd2);
      seen = 0;
      repeat (40) begin
         @(posedge clk); #1;
         if (ov32) seen++;
      end
      check("flush no valid", 32'(seen), 32'd0);

      // Flush during DONE of a fast-path op
      drive(1'b0, 1'b1, 3'd5, 32'h55, 32'd0);
      @(posedge clk); #1;
      drive(1'b0, 1'b0, 3'd0, 32'd0, 32'd0);
      check("fast done valid", {31'd0, ov32}, 32'd1);
      flush = 1'b1;
      #1;
      check("flush done valid", {31'd0, ov32}, 32'd0);
      @(posedge clk); #1;
      flush = 1'b0;
      check("flush done ready", {31'd0, r32}, 32'd1);
      check("flush done data", d32, 32'hFFFF_FFFF);

      // Flush in IDLE blocks accept
      flush = 1'b1;
      drive(1'b0, 1'b1, 3'd0, 32'd3, 32'd4);
      @(posedge clk); #1;
      flush = 1'b0;
      drive(1'b0, 1'b0, 3'd0, 32'd0, 32'd0);
      check("idle flush blocks", {31'd0, busy32}, 32'd0);

      // Reset mid-operation
      drive(1'b0, 1'b1, 3'd0, 32'd12345, 32'd678);
      for (int c = 1; c <= 20; c++) begin
         @(posedge clk); #1;
         drive(1'b0, 1'b0, 3'($urandom_range(0, 7)), $urandom, $urandom);
      end
      rst = 1'b1;
      #1;
      check("midreset data", d32, 32'd0);
      check("midreset valid", {31'd0, ov32}, 32'd0);
      check("midreset busy", {31'd0, busy32}, 32'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      @(posedge clk); #1;
      run_op(1'b0, 3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, res, lat, ok);
      check("post-reset data", res, 32'hFFFF_FFFE);
      check("post-reset cycle", 32'(lat), 32'd33);

      // Random back-to-back with i_valid held high and operands scrambled mid-op
      begin
         int t, acc_t, exp_sp, issued;
         logic [2:0] rop;
         logic [31:0] ra, rb, got;
         int k;
         bit fast;
         t = 0; acc_t = -1; exp_sp = 0; issued = 0;
         while (t < 3000) begin
            if (ov32) begin
               if (exp_q.size() == 0) begin
                  check("rand unexpected valid", 32'd1, 32'd0);
               end else begin
                  got = exp_q.pop_front();
                  check($sformatf("rand data t=%0d", t), d32, got);
               end
            end
            if (r32) begin
               if (acc_t >= 0) check($sformatf("rand spacing t=%0d", t), 32'(t - acc_t), 32'(exp_sp));
               acc_t = -1;
               if (issued < 40) begin
                  rop = 3'($urandom_range(0, 7));
                  ra = ($urandom_range(0, 7) == 0) ? 32'h8000_0000 : $urandom;
                  k = $urandom_range(0, 9);
                  rb = (k == 0) ? 32'd0 : (k == 1) ? 32'hFFFF_FFFF :
                       (k == 2) ? 32'($urandom_range(1, 15)) : $urandom;
                  fast = rop[2] && (rb == 0 || (!rop[0] && ra == 32'h8000_0000 && rb == 32'hFFFF_FFFF));
                  exp_sp = fast ? 2 : 34;
                  exp_q.push_back(ref_md(rop, ra, rb));
                  drive(1'b0, 1'b1, rop, ra, rb);
                  acc_t = t;
                  issued++;
               end else begin
                  drive(1'b0, 1'b0, 3'd0, 32'd0, 32'd0);
                  if (exp_q.size() == 0) break;
               end
            end else begin
               drive(1'b0, issued < 40, 3'($urandom_range(0, 7)), $urandom, $urandom);
            end
            @(posedge clk); #1;
            t++;
         end
         check("rand all issued", 32'(issued), 32'd40);
         check("rand all returned", 32'(exp_q.size()), 32'd0);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
